// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register byte offsets, bus access
// size encoding and the write-lane mask helper.
package gpio_pkg;

   localparam logic [1:0] WR_BYTE = 2'b00;
   localparam logic [1:0] WR_HALF = 2'b01;
   localparam logic [1:0] WR_WORD = 2'b10;
   localparam logic [1:0] WR_NONE = 2'b11;

   localparam logic [31:0] OFF_OUT     = 32'h0000_0000;
   localparam logic [31:0] OFF_IN      = 32'h0000_0004;
   localparam logic [31:0] OFF_OE      = 32'h0000_0008;
   localparam logic [31:0] OFF_SET     = 32'h0000_000C;
   localparam logic [31:0] OFF_CLR     = 32'h0000_0010;
   localparam logic [31:0] OFF_TGL     = 32'h0000_0014;
   localparam logic [31:0] OFF_RISE_EN = 32'h0000_0018;
   localparam logic [31:0] OFF_FALL_EN = 32'h0000_001C;
   localparam logic [31:0] OFF_STATUS  = 32'h0000_0020;

   // Byte lanes touched by an access of the given size; no access touches nothing.
   function automatic logic [31:0] width_mask(input logic [1:0] size);
      logic [31:0] mask;
      case (size)
         WR_BYTE: mask = 32'h0000_00FF;
         WR_HALF: mask = 32'h0000_FFFF;
         WR_WORD: mask = 32'hFFFF_FFFF;
         default: mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for the asynchronous pad inputs.
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Shift the pad value through the chain; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// GPIO peripheral: output/OE registers with atomic set/clear/toggle,
// synchronised inputs and sticky W1C edge interrupts.
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        write_n,
   input  logic [1:0]        read_n,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   input  logic [WIDTH-1:0]  gpio_in,
   output logic [WIDTH-1:0]  gpio_out,
   output logic [WIDTH-1:0]  gpio_oe,
   output logic              irq
);

   localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

   logic [31:0]      off_s;
   logic [31:0]      mask_s;
   logic             wr_s;
   logic             capture_s;
   logic [WIDTH-1:0] wmask_s, wdata_s, in_s, out_nxt_s, w1c_s, rise_s, fall_s;
   logic [WIDTH-1:0] out_r, oe_r, rise_en_r, fall_en_r, status_r, prev_r;
   logic             irq_r;
   logic [2:0]       warm_r;
   logic [31:0]      rdata_s;
   logic             unused_s;

   gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gpio_in),
      .q   (in_s)
   );

   // Address decode, write lane masking and next value of the output register.
   always_comb begin
      off_s     = 32'({addr[ADDR_W-1:2], 2'b00});
      wr_s      = sel && (write_n != WR_NONE);
      mask_s    = width_mask(write_n);
      wmask_s   = mask_s[WIDTH-1:0];
      wdata_s   = data_in[WIDTH-1:0] & wmask_s;
      out_nxt_s = out_r;
      if (wr_s) begin
         case (off_s)
            OFF_OUT: out_nxt_s = (out_r & ~wmask_s) | wdata_s;
            OFF_SET: out_nxt_s = out_r | wdata_s;
            OFF_CLR: out_nxt_s = out_r & ~wdata_s;
            OFF_TGL: out_nxt_s = out_r ^ wdata_s;
            default: out_nxt_s = out_r;
         endcase
      end else begin
         out_nxt_s = out_r;
      end
   end

   // Edge qualification; capture is held off until the synchroniser and prev have settled.
   always_comb begin
      capture_s = (warm_r == WARM_CYCLES);
      w1c_s     = (wr_s && (off_s == OFF_STATUS)) ? wdata_s : {WIDTH{1'b0}};
      if (capture_s) begin
         rise_s = in_s & ~prev_r & rise_en_r;
         fall_s = ~in_s & prev_r & fall_en_r;
      end else begin
         rise_s = {WIDTH{1'b0}};
         fall_s = {WIDTH{1'b0}};
      end
   end

   // Register file, edge history, sticky status, warm-up counter and irq.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r     <= {WIDTH{1'b0}};
         oe_r      <= {WIDTH{1'b0}};
         rise_en_r <= {WIDTH{1'b0}};
         fall_en_r <= {WIDTH{1'b0}};
         status_r  <= {WIDTH{1'b0}};
         prev_r    <= {WIDTH{1'b0}};
         irq_r     <= 1'b0;
         warm_r    <= 3'd0;
      end else begin
         out_r <= out_nxt_s;
         if (wr_s && (off_s == OFF_OE)) begin
            oe_r <= (oe_r & ~wmask_s) | wdata_s;
         end
         if (wr_s && (off_s == OFF_RISE_EN)) begin
            rise_en_r <= (rise_en_r & ~wmask_s) | wdata_s;
         end
         if (wr_s && (off_s == OFF_FALL_EN)) begin
            fall_en_r <= (fall_en_r & ~wmask_s) | wdata_s;
         end
         // A fresh edge outranks a simultaneous W1C of the same bit.
         status_r <= (status_r & ~w1c_s) | rise_s | fall_s;
         prev_r   <= in_s;
         irq_r    <= |status_r;
         if (warm_r != WARM_CYCLES) begin
            warm_r <= warm_r + 3'd1;
         end
      end
   end

   // Read mux; write-only and unmapped offsets read all ones.
   always_comb begin
      rdata_s = 32'h0000_0000;
      if (sel && (read_n != WR_NONE)) begin
         case (off_s)
            OFF_OUT:     rdata_s = 32'(out_r);
            OFF_IN:      rdata_s = 32'(in_s);
            OFF_OE:      rdata_s = 32'(oe_r);
            OFF_RISE_EN: rdata_s = 32'(rise_en_r);
            OFF_FALL_EN: rdata_s = 32'(fall_en_r);
            OFF_STATUS:  rdata_s = 32'(status_r);
            default:     rdata_s = 32'hFFFF_FFFF;
         endcase
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   assign data_out = rdata_s;
   assign gpio_out = out_r;
   assign gpio_oe  = oe_r;
   assign irq      = irq_r;
   assign unused_s = ^{addr[1:0], data_in, mask_s};

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: an 8-pin instance for registers/edges and a
// 32-pin instance for partial-width writes.
module tb_gpio_bank;
   import gpio_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel8, sel32;
   logic [5:0]  addr;
   logic [1:0]  write_n, read_n;
   logic [31:0] data_in;
   logic [31:0] dout8, dout32;
   logic [7:0]  gin8, gout8, goe8;
   logic [31:0] gin32, gout32, goe32;
   logic        irq8, irq32;

   typedef struct {
      bit          big;
      logic [31:0] data;
      bit          chk_irq;
      logic        irq;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    tests = 0;
   int    fails = 0;

   exp_t        mon_e;
   string       mon_n;
   logic [31:0] mon_d;
   logic        mon_i;

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .ADDR_W(6)) dut8 (
      .clk(clk), .rst(rst), .sel(sel8), .addr(addr), .write_n(write_n),
      .read_n(read_n), .data_in(data_in), .data_out(dout8), .gpio_in(gin8),
      .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
   );

   gpio_bank #(.WIDTH(32), .SYNC_STAGES(2), .ADDR_W(6)) dut32 (
      .clk(clk), .rst(rst), .sel(sel32), .addr(addr), .write_n(write_n),
      .read_n(read_n), .data_in(data_in), .data_out(dout32), .gpio_in(gin32),
      .gpio_out(gout32), .gpio_oe(goe32), .irq(irq32)
   );

   // Monitor: every read strobe pops one expectation and compares mid-cycle.
   always @(negedge clk) begin
      if (read_n != WR_NONE) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read: got data_out8=%h with no expectation queued", dout8);
         end else begin
            mon_e = sb_q.pop_front();
            mon_n = nm_q.pop_front();
            mon_d = mon_e.big ? dout32 : dout8;
            tests++;
            if (mon_d !== mon_e.data) begin
               fails++;
               $display("FAIL %s: data_out=%h expected %h", mon_n, mon_d, mon_e.data);
            end
            if (mon_e.chk_irq) begin
               mon_i = mon_e.big ? irq32 : irq8;
               tests++;
               if (mon_i !== mon_e.irq) begin
                  fails++;
                  $display("FAIL %s_irq: irq=%b expected %b", mon_n, mon_i, mon_e.irq);
               end
            end
         end
      end
   end

   task automatic op(input bit big, input bit s, input logic [31:0] off,
                     input logic [1:0] wn, input logic [1:0] rn, input logic [31:0] d);
      sel8    = s && !big;
      sel32   = s && big;
      addr    = off[5:0];
      write_n = wn;
      read_n  = rn;
      data_in = d;
      @(posedge clk);
      #1;
      sel8    = 1'b0;
      sel32   = 1'b0;
      addr    = 6'h00;
      write_n = WR_NONE;
      read_n  = WR_NONE;
      data_in = 32'h0000_0000;
   endtask

   task automatic wr(input bit big, input logic [31:0] off, input logic [1:0] wn,
                     input logic [31:0] d);
      op(big, 1'b1, off, wn, WR_NONE, d);
   endtask

   task automatic rd(input bit big, input bit s, input logic [31:0] off,
                     input logic [31:0] exp_d, input bit chk, input logic exp_i,
                     input string name);
      exp_t e;
      e.big     = big;
      e.data    = exp_d;
      e.chk_irq = chk;
      e.irq     = exp_i;
      sb_q.push_back(e);
      nm_q.push_back(name);
      op(big, s, off, WR_NONE, WR_WORD, 32'h0000_0000);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      sel8    = 1'b0;
      sel32   = 1'b0;
      addr    = 6'h00;
      write_n = WR_NONE;
      read_n  = WR_NONE;
      data_in = 32'h0000_0000;
      gin8    = 8'hFF;
      gin32   = 32'h0000_0000;
      repeat (3) @(posedge clk);
      #1;

      // Reset / warm-up: pins already high and RISE_EN set straight away.
      rst = 1'b0;
      wr(1'b0, OFF_RISE_EN, WR_WORD, 32'h0000_00FF);
      rd(1'b0, 1'b1, OFF_IN,     32'h0000_0000, 1'b0, 1'b0, "in_latency");
      rd(1'b0, 1'b1, OFF_IN,     32'h0000_00FF, 1'b0, 1'b0, "in_sync");
      rd(1'b0, 1'b1, OFF_OUT,    32'h0000_0000, 1'b1, 1'b0, "reset_out");
      rd(1'b0, 1'b1, OFF_OE,     32'h0000_0000, 1'b0, 1'b0, "reset_oe");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0000, 1'b1, 1'b0, "warmup_status");
      idle(3);
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0000, 1'b1, 1'b0, "warmup_status2");
      gin8 = 8'h00;
      idle(4);
      wr(1'b0, OFF_RISE_EN, WR_WORD, 32'h0000_0000);

      // Atomic ops and decode corners.
      wr(1'b0, OFF_OUT, WR_WORD, 32'h0000_000F);
      rd(1'b0, 1'b1, OFF_OUT, 32'h0000_000F, 1'b0, 1'b0, "out_init");
      wr(1'b0, OFF_SET, WR_WORD, 32'h0000_00F0);
      rd(1'b0, 1'b1, OFF_OUT, 32'h0000_00FF, 1'b0, 1'b0, "set");
      wr(1'b0, OFF_CLR, WR_WORD, 32'h0000_0081);
      rd(1'b0, 1'b1, OFF_OUT, 32'h0000_007E, 1'b0, 1'b0, "clr");
      wr(1'b0, OFF_TGL, WR_WORD, 32'h0000_00FF);
      rd(1'b0, 1'b1, OFF_OUT, 32'h0000_0081, 1'b0, 1'b0, "tgl");
      wr(1'b0, 32'h0000_0024, WR_WORD, 32'hFFFF_FFFF);
      rd(1'b0, 1'b1, OFF_OUT, 32'h0000_0081, 1'b0, 1'b0, "unmapped_wr");
      rd(1'b0, 1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0, 1'b0, "unmapped_rd");
      rd(1'b0, 1'b1, OFF_SET, 32'hFFFF_FFFF, 1'b0, 1'b0, "wo_rd");
      rd(1'b0, 1'b0, OFF_OUT, 32'h0000_0000, 1'b0, 1'b0, "nosel_rd");
      wr(1'b0, OFF_OE, WR_WORD, 32'hFFFF_FF5A);
      rd(1'b0, 1'b1, OFF_OE, 32'h0000_005A, 1'b0, 1'b0, "oe");

      // Edge interrupts.
      gin8 = 8'h02;
      idle(4);
      wr(1'b0, OFF_RISE_EN, WR_WORD, 32'h0000_0001);
      wr(1'b0, OFF_FALL_EN, WR_WORD, 32'h0000_0002);
      gin8 = 8'h03;
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0000, 1'b1, 1'b0, "rise_c0");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0000, 1'b1, 1'b0, "rise_c1");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0000, 1'b1, 1'b0, "rise_c2");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0001, 1'b1, 1'b0, "rise_c3");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0001, 1'b1, 1'b1, "rise_irq");
      gin8 = 8'h01;
      idle(3);
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0003, 1'b1, 1'b1, "fall");
      wr(1'b0, OFF_STATUS, WR_WORD, 32'h0000_0001);
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0002, 1'b1, 1'b1, "w1c");

      // Collision: W1C lands on the same edge as a new rise of pin0.
      gin8 = 8'h02;
      idle(4);
      gin8 = 8'h03;
      idle(2);
      wr(1'b0, OFF_STATUS, WR_WORD, 32'h0000_0001);
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0003, 1'b1, 1'b1, "collision");

      // Mid-operation reset with pins high.
      wr(1'b0, OFF_OUT, WR_WORD, 32'h0000_00AA);
      rd(1'b0, 1'b1, OFF_OUT,    32'h0000_00AA, 1'b0, 1'b0, "pre_rst_out");
      rd(1'b0, 1'b1, OFF_STATUS, 32'h0000_0003, 1'b0, 1'b0, "pre_rst_status");
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      wr(1'b0, OFF_RISE_EN, WR_WORD, 32'h0000_00FF);
      rd(1'b0, 1'b1, OFF_OUT,     32'h0000_0000, 1'b1, 1'b0, "rst_out");
      rd(1'b0, 1'b1, OFF_OE,      32'h0000_0000, 1'b0, 1'b0, "rst_oe");
      rd(1'b0, 1'b1, OFF_STATUS,  32'h0000_0000, 1'b1, 1'b0, "rst_status");
      rd(1'b0, 1'b1, OFF_FALL_EN, 32'h0000_0000, 1'b0, 1'b0, "rst_fall_en");
      rd(1'b0, 1'b1, OFF_RISE_EN, 32'h0000_00FF, 1'b0, 1'b0, "rst_rise_en");
      rd(1'b0, 1'b1, OFF_STATUS,  32'h0000_0000, 1'b1, 1'b0, "rst_warmup");

      // Partial-width writes on the 32-pin instance.
      wr(1'b1, OFF_OUT, WR_WORD, 32'h1234_5678);
      rd(1'b1, 1'b1, OFF_OUT, 32'h1234_5678, 1'b0, 1'b0, "w32_word");
      wr(1'b1, OFF_OUT, WR_BYTE, 32'hFFFF_FFAB);
      rd(1'b1, 1'b1, OFF_OUT, 32'h1234_56AB, 1'b0, 1'b0, "w32_byte");
      wr(1'b1, OFF_OUT, WR_HALF, 32'hFFFF_CDEF);
      rd(1'b1, 1'b1, OFF_OUT, 32'h1234_CDEF, 1'b0, 1'b0, "w32_half");

      idle(2);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
